// File: rtl/dvp_pkg.sv
// dvp_pkg
// Shared types and constants for the dvp magnitude path.
//   mag_t      : 8-bit unsigned gradient magnitude
//   user_t     : 2-bit sideband {sof, eol}
//   out_word_t : one output-FIFO entry, sideband above magnitude
//   SQ_W       : width of the squared-sum word sent to the sqrt core
//   square8()  : square of a signed 8-bit gradient as a 15-bit unsigned value
package dvp_pkg;

    localparam int SQ_W   = 16;
    localparam int MAG_W  = 8;
    localparam int USER_W = 2;

    typedef logic [MAG_W-1:0]  mag_t;
    typedef logic [USER_W-1:0] user_t;

    typedef struct packed {
        user_t user;
        mag_t  mag;
    } out_word_t;

    localparam int OUT_W = $bits(out_word_t);

    // Squaring through the absolute value keeps the multiply unsigned.
    // For -128 the 8-bit negation wraps back to 8'h80, which read as
    // unsigned is exactly 128, so no special case is needed.
    function automatic logic [14:0] square8(input logic signed [7:0] v);
        logic [7:0] a;
        a = v[7] ? 8'(-v) : 8'(v);
        return 15'(a) * 15'(a);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever the FIFO is non-empty; rd_en pops it.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en, wr_data  : push request and data (ignored when full unless a pop
//                     happens in the same cycle)
//   rd_en           : pop request (ignored when empty)
//   rd_data         : head entry, forced to zero while empty
//   full, empty     : status from pointer comparison
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO still takes
    // a push when it is also being read.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Zero while empty so the downstream outputs sit at zero after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_feed.sv
// sqrt_feed
// Front and back end around the sqrt CORDIC core in the magnitude path.
// Incoming signed gradient pairs are squared and summed in two registered
// stages and handed to the core. Each core result is re-paired with the
// sideband of its input and queued on a backpressurable output stream.
// The core cannot stall, so a credit counter limits how many items may be
// anywhere between input accept and output pop.
// Ports:
//   clk, rst_n                 : clock (shared with the core), async active-low reset
//   s_gx, s_gy, s_user         : signed gradient pair and {sof, eol} sideband
//   s_valid, s_ready           : input handshake
//   cart_tdata, cart_tvalid    : gx^2 + gy^2 to the core cartesian input
//   sqrt_tdata, sqrt_tvalid    : core result, magnitude in [7:0]
//   m_mag, m_user              : output magnitude and its sideband
//   m_valid, m_ready           : output handshake
//   err                        : sticky protocol error
module sqrt_feed
    import dvp_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [7:0] s_gx,
    input  logic signed [7:0] s_gy,
    input  user_t             s_user,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [SQ_W-1:0]   cart_tdata,
    output logic              cart_tvalid,
    input  logic [SQ_W-1:0]   sqrt_tdata,
    input  logic              sqrt_tvalid,
    output mag_t              m_mag,
    output user_t             m_user,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              err
);

    localparam int            CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

    logic            accept;
    logic            out_pop;
    logic [14:0]     sq_x;
    logic [14:0]     sq_y;
    logic            st1_valid;
    logic [CW-1:0]   credit;

    user_t           sb_user;
    logic            sb_full;
    logic            sb_empty;

    out_word_t       out_wdata;
    out_word_t       out_rdata;
    logic            out_push;
    logic            out_full;
    logic            out_empty;

    // Only the low byte of the core output carries the magnitude.
    logic            unused_sqrt_hi;
    assign unused_sqrt_hi = ^sqrt_tdata[SQ_W-1:8];

    // s_ready depends only on the credit register, never on s_valid, so the
    // upstream can never form a combinational loop through this block.
    assign s_ready = (credit != CREDIT_MAX);
    assign accept  = s_valid && s_ready;
    assign out_pop = m_valid && m_ready;

    // Stage 1: square both components. Each square fits in 15 bits since
    // the largest is (-128)^2 = 16384.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_x      <= '0;
            sq_y      <= '0;
            st1_valid <= 1'b0;
        end else begin
            st1_valid <= accept;
            if (accept) begin
                sq_x <= square8(s_gx);
                sq_y <= square8(s_gy);
            end
        end
    end

    // Stage 2: 16-bit sum to the core. The largest sum is 32768, so the
    // extra bit alone is enough and nothing saturates. The data is held
    // between valid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cart_tdata  <= '0;
            cart_tvalid <= 1'b0;
        end else begin
            cart_tvalid <= st1_valid;
            if (st1_valid) begin
                cart_tdata <= {1'b0, sq_x} + {1'b0, sq_y};
            end
        end
    end

    // Sideband rides alongside the core in its own FIFO: pushed on accept,
    // popped as each result comes back. Core order equals input order.
    sync_fifo_fwft #(
        .WIDTH (USER_W),
        .DEPTH (DEPTH)
    ) u_sideband_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (s_user),
        .rd_en   (sqrt_tvalid),
        .rd_data (sb_user),
        .full    (sb_full),
        .empty   (sb_empty)
    );

    // A result with no matching sideband is discarded rather than queued
    // with a made-up sideband.
    assign out_push       = sqrt_tvalid && !sb_empty;
    assign out_wdata.user = sb_user;
    assign out_wdata.mag  = sqrt_tdata[7:0];

    sync_fifo_fwft #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_output_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (out_push),
        .wr_data (out_wdata),
        .rd_en   (m_ready),
        .rd_data (out_rdata),
        .full    (out_full),
        .empty   (out_empty)
    );

    assign m_valid = !out_empty;
    assign m_mag   = out_rdata.mag;
    assign m_user  = out_rdata.user;

    // Credit counts every item between accept and output pop, which covers
    // the two pipeline stages, the core and both FIFOs. Accept and pop in
    // the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else begin
            case ({accept, out_pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    // Sticky error: an orphan core result, or a push into a full output
    // FIFO that no simultaneous pop makes room for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((sqrt_tvalid && sb_empty) ||
                     (out_push && out_full && !out_pop)) begin
            err <= 1'b1;
        end
    end

    // The credit limit keeps the sideband FIFO from ever being pushed while
    // full, and keeps the counter from going below zero.
    a_sideband_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) !(accept && sb_full));

    a_credit_no_underflow : assert property (
        @(posedge clk) disable iff (!rst_n) !(out_pop && (credit == '0)));

endmodule

// File: tb/tb_sqrt_feed.sv
// tb_sqrt_feed
// Scoreboard bench for sqrt_feed. A behavioural sqrt core (integer square
// root, fixed latency) closes the loop between cart_* and sqrt_*. The driver
// computes the expected sum and magnitude for every accepted pair with plain
// integer arithmetic and queues them; a monitor on the falling edge pops and
// compares whenever the DUT presents cart_tvalid or an output handshake.
module tb_sqrt_feed;

    localparam int LAT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [7:0] s_gx;
    logic signed [7:0] s_gy;
    logic [1:0]        s_user;
    logic              s_valid;
    logic              s_ready;
    logic [15:0]       cart_tdata;
    logic              cart_tvalid;
    logic [15:0]       sqrt_tdata;
    logic              sqrt_tvalid;
    logic [7:0]        m_mag;
    logic [1:0]        m_user;
    logic              m_valid;
    logic              m_ready;
    logic              err;

    always #5 clk = ~clk;

    sqrt_feed #(.DEPTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_gx        (s_gx),
        .s_gy        (s_gy),
        .s_user      (s_user),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .cart_tdata  (cart_tdata),
        .cart_tvalid (cart_tvalid),
        .sqrt_tdata  (sqrt_tdata),
        .sqrt_tvalid (sqrt_tvalid),
        .m_mag       (m_mag),
        .m_user      (m_user),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .err         (err)
    );

    int tests  = 0;
    int failed = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int sum;
        int cyc;
    } cart_exp_t;

    cart_exp_t  cart_q [$];
    logic [9:0] m_q    [$];

    function automatic int isqrt(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural sqrt core: fixed latency, reset together with the DUT.
    logic [7:0] core_d [LAT];
    logic       core_v [LAT];
    logic       inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) core_v[i] <= 1'b0;
        end else begin
            core_v[0] <= cart_tvalid;
            core_d[0] <= 8'(isqrt(int'(cart_tdata)));
            for (int i = 1; i < LAT; i++) begin
                core_v[i] <= core_v[i-1];
                core_d[i] <= core_d[i-1];
            end
        end
    end

    assign sqrt_tvalid = core_v[LAT-1] | inj;
    assign sqrt_tdata  = {8'h00, core_d[LAT-1]};

    // Monitor: pops expectations whenever the DUT presents data, and checks
    // that a stalled output holds still.
    cart_exp_t  ce;
    logic       hold_v = 1'b0;
    logic [9:0] hold_w;
    logic [9:0] me;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            hold_v = 1'b0;
        end else begin
            if (cart_tvalid) begin
                if (cart_q.size() == 0) begin
                    check_output("cart_unexpected", 0, 1);
                end else begin
                    ce = cart_q.pop_front();
                    check_output("cart_tdata", 32'(cart_tdata), ce.sum);
                    check_output("cart_latency", cycle - ce.cyc, 2);
                end
            end
            if (hold_v) begin
                check_output("hold_stable", {m_valid, m_user, m_mag}, {1'b1, hold_w});
            end
            if (m_valid && m_ready) begin
                if (m_q.size() == 0) begin
                    check_output("m_unexpected", 0, 1);
                end else begin
                    me = m_q.pop_front();
                    check_output("m_out", {m_user, m_mag}, me);
                end
            end
            hold_v = m_valid && !m_ready;
            hold_w = {m_user, m_mag};
        end
    end

    // Drives one pair and waits for it to be taken. Expectations are queued
    // at the falling edge before the accepting rising edge. Returns #1 after
    // that rising edge with s_valid still high.
    task automatic apply_stimulus(input int gx, input int gy, input logic [1:0] user,
                                  output int waits);
        bit taken;
        int sum;
        taken  = 1'b0;
        waits  = 0;
        s_gx   = 8'(gx);
        s_gy   = 8'(gy);
        s_user = user;
        s_valid = 1'b1;
        sum = gx * gx + gy * gy;
        for (int t = 0; t < 200 && !taken; t++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                cart_q.push_back('{sum, cycle});
                m_q.push_back({user, 8'(isqrt(sum))});
                taken = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!taken) begin
            tests++;
            failed++;
            $display("[TB] FAIL accept_timeout: pair (%0d,%0d) not accepted", gx, gy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit drained;
        drained = 1'b0;
        for (int t = 0; t < 500 && !drained; t++) begin
            @(negedge clk);
            drained = (cart_q.size() == 0) && (m_q.size() == 0);
        end
        check_output("drain", {16'(cart_q.size()), 16'(m_q.size())}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_s_ready"},     s_ready,     1);
        check_output({tag, "_cart_tvalid"}, cart_tvalid, 0);
        check_output({tag, "_cart_tdata"},  cart_tdata,  0);
        check_output({tag, "_m_valid"},     m_valid,     0);
        check_output({tag, "_m_mag"},       m_mag,       0);
        check_output({tag, "_m_user"},      m_user,      0);
        check_output({tag, "_err"},         err,         0);
    endtask

    function automatic int rnd_g();
        return int'($urandom_range(255)) - 128;
    endfunction

    bit done;
    int w;
    int d17x, d17y, d18x, d18y;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_gx    = '0;
        s_gy    = '0;
        s_user  = '0;
        m_ready = 1'b0;
        inj     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;

        // Single pair (3,4): sum 25, magnitude 5, m_valid one cycle after
        // the core result.
        m_ready = 1'b1;
        apply_stimulus(3, 4, 2'b10, w);
        s_valid = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 40 && !seen; t++) begin
                @(negedge clk);
                seen = sqrt_tvalid;
            end
            check_output("sqrt_tvalid_seen", seen, 1);
            check_output("m_valid_before", m_valid, 0);
            @(negedge clk);
            check_output("m_valid_k1", m_valid, 1);
            check_output("m_mag_3_4", m_mag, 5);
            check_output("m_user_3_4", m_user, 2'b10);
        end
        wait_drain();

        // Extremes back to back.
        apply_stimulus(-128, -128, 2'b01, w);
        apply_stimulus(127, 0, 2'b00, w);
        apply_stimulus(0, 0, 2'b11, w);
        s_valid = 1'b0;
        wait_drain();

        // Fill all credits with the output stalled.
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(rnd_g(), rnd_g(), 2'($urandom_range(3)), w);
        end
        s_valid = 1'b0;
        @(negedge clk);
        check_output("full_after_16", s_ready, 0);
        repeat (14) @(posedge clk);
        #1;
        check_output("full_after_drain", s_ready, 0);
        d17x = rnd_g(); d17y = rnd_g();
        d18x = rnd_g(); d18y = rnd_g();
        s_gx    = 8'(d17x);
        s_gy    = 8'(d17y);
        s_user  = 2'b01;
        s_valid = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        check_output("no_accept_while_full", s_ready, 0);
        @(posedge clk);
        #1;
        // The pop has freed one credit: accepted with no wait while a
        // second pop happens in the same cycle.
        apply_stimulus(d17x, d17y, 2'b01, w);
        check_output("accept_next_cycle", w, 0);
        m_ready = 1'b0;
        apply_stimulus(d18x, d18y, 2'b10, w);
        check_output("accept_at_depth_minus_1", w, 0);
        s_valid = 1'b0;
        @(negedge clk);
        check_output("credit_hold", s_ready, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_drain();
        check_output("err_after_flow", err, 0);

        // Orphan core result.
        inj = 1'b1;
        @(posedge clk);
        #1;
        inj = 1'b0;
        @(negedge clk);
        check_output("err_set", err, 1);
        check_output("err_no_m_valid", m_valid, 0);
        repeat (5) @(negedge clk);
        check_output("err_sticky", err, 1);
        check_output("err_still_no_m_valid", m_valid, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("err_cleared", err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Asynchronous reset with items in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(rnd_g(), rnd_g(), 2'($urandom_range(3)), w);
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        cart_q.delete();
        m_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_rst_ready", s_ready, 1);
        @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    apply_stimulus(rnd_g(), rnd_g(), 2'($urandom_range(3)), w);
                    if ($urandom_range(3) == 0) begin
                        s_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                s_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(1));
                end
                m_ready = 1'b1;
            end
        join
        wait_drain();
        check_output("err_final", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
